// File: rtl/gear_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// gear_input_conditioner_if
//
// Groups the raw pad inputs and the conditioned outputs of the gearbox
// front end into one bundle.
//
//   ena          design enable (low freezes the conditioner)
//   wheel_raw    asynchronous wheel-sensor pulse
//   btn_raw[2:0] asynchronous buttons: [0] throttle, [1] brake, [2] drive/park
//   speed        rising wheel edges counted in the last completed window
//   speed_valid  one-cycle strobe when speed/overflow update
//   overflow     last completed window saturated
//   btn_level    debounced button levels
//   btn_rise     one-cycle pulse on each debounced 0->1 button change
//
// Modports:
//   master  the conditioner, which produces the conditioned signals
//   slave   the consumer side, which drives the raw inputs and enable
//
// Handshake: speed_valid is a strobe with no back-pressure. The consumer
// must take speed/overflow in the strobe cycle; both values are then held
// unchanged until the next strobe. btn_rise is likewise a single-cycle
// pulse that cannot be stalled.
// ---------------------------------------------------------------------------
interface gear_input_conditioner_if #(
  parameter int SPEED_W = 8
);
  logic               ena;
  logic               wheel_raw;
  logic [2:0]         btn_raw;
  logic [SPEED_W-1:0] speed;
  logic               speed_valid;
  logic               overflow;
  logic [2:0]         btn_level;
  logic [2:0]         btn_rise;

  modport master (
    input  ena, wheel_raw, btn_raw,
    output speed, speed_valid, overflow, btn_level, btn_rise
  );

  modport slave (
    output ena, wheel_raw, btn_raw,
    input  speed, speed_valid, overflow, btn_level, btn_rise
  );
endinterface

// File: rtl/gear_input_conditioner.sv
// ---------------------------------------------------------------------------
// gear_input_conditioner
//
// Front end for the automatic-gearbox shift FSM. Synchronizes the raw pad
// inputs, measures the wheel-pulse rate over a fixed gate window and
// debounces the three driver buttons.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset (dominates ena)
//   bus   gear_input_conditioner_if.master (raw inputs in, conditioned
//         speed / strobe / overflow / button level and rise out)
//
// Parameters:
//   GATE_CYCLES      clocks per speed-measurement window (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable clocks to accept a button change (>= 1)
//   SPEED_W          width of the speed code
//
// Optional feature macro: GIC_SPEED_AVG_EN
//   defined   : speed = (current + previous window count) >> 1, both counts
//               saturated, summed on SPEED_W+1 bits. overflow still reflects
//               the current window only.
//   undefined : speed is the saturated current-window count.
//
// No state machine here: the window and debounce counters are plain
// counters.
// ---------------------------------------------------------------------------
module gear_input_conditioner #(
  parameter int GATE_CYCLES     = 25000,
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int SPEED_W         = 8
) (
  input logic                      clk,
  input logic                      rst,
  gear_input_conditioner_if.master bus
);

  localparam int WIN_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SPEED_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stages: bit 3 is the wheel, bits [2:0] the buttons.
  logic [3:0]               sync1_q, sync1_d;
  logic [3:0]               sync2_q, sync2_d;
  logic                     wheel3_q, wheel3_d;

  logic [WIN_W-1:0]         win_q, win_d;
  logic [SPEED_W-1:0]       pulse_q, pulse_d;
  // An edge arrived while the pulse count was already saturated.
  logic                     sat_hit_q, sat_hit_d;

  logic [SPEED_W-1:0]       speed_q, speed_d;
  logic                     speed_valid_q, speed_valid_d;
  logic                     overflow_q, overflow_d;

  logic [2:0][DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [2:0]               level_q, level_d;
  logic [2:0]               level_dly_q, level_dly_d;
  logic [2:0]               rise_q, rise_d;

`ifdef GIC_SPEED_AVG_EN
  logic [SPEED_W-1:0]       prev_q, prev_d;
  logic [SPEED_W:0]         avg_sum;
`endif

  // Wheel edge detect and the count as it stands including this cycle's
  // edge, which is what the terminal cycle reports.
  logic               wheel_edge;
  logic               terminal;
  logic [SPEED_W-1:0] cnt_now;
  logic               ovf_now;

  always_comb begin
    wheel_edge = sync2_q[3] & ~wheel3_q;
    terminal   = (win_q == WIN_LAST);
    cnt_now    = pulse_q;
    ovf_now    = sat_hit_q;
    if (wheel_edge) begin
      if (pulse_q == CNT_MAX) begin
        ovf_now = 1'b1;
      end else begin
        cnt_now = pulse_q + 1'b1;
      end
    end
  end

`ifdef GIC_SPEED_AVG_EN
  always_comb begin
    avg_sum = {1'b0, cnt_now} + {1'b0, prev_q};
  end
`endif

  // Synchronizers, window counter and speed measurement.
  always_comb begin
    sync1_d       = sync1_q;
    sync2_d       = sync2_q;
    wheel3_d      = wheel3_q;
    win_d         = win_q;
    pulse_d       = pulse_q;
    sat_hit_d     = sat_hit_q;
    speed_d       = speed_q;
    overflow_d    = overflow_q;
    speed_valid_d = 1'b0;
`ifdef GIC_SPEED_AVG_EN
    prev_d        = prev_q;
`endif
    if (bus.ena) begin
      sync1_d  = {bus.wheel_raw, bus.btn_raw};
      sync2_d  = sync1_q;
      wheel3_d = sync2_q[3];
      if (terminal) begin
        win_d         = '0;
        pulse_d       = '0;
        sat_hit_d     = 1'b0;
        overflow_d    = ovf_now;
        speed_valid_d = 1'b1;
`ifdef GIC_SPEED_AVG_EN
        speed_d       = avg_sum[SPEED_W:1];
        prev_d        = cnt_now;
`else
        speed_d       = cnt_now;
`endif
      end else begin
        win_d     = win_q + 1'b1;
        pulse_d   = cnt_now;
        sat_hit_d = ovf_now;
      end
    end
  end

  // Button debounce. The level toggles on the clock where the mismatch
  // counter would reach DEBOUNCE_CYCLES; the rise pulse follows one
  // enabled clock later, so level and pulse never rise together.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    level_d     = level_q;
    level_dly_d = level_dly_q;
    rise_d      = '0;
    if (bus.ena) begin
      rise_d      = level_q & ~level_dly_q;
      level_dly_d = level_q;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] == level_q[b]) begin
          db_cnt_d[b] = '0;
        end else if (db_cnt_q[b] == DB_LAST) begin
          db_cnt_d[b] = '0;
          level_d[b]  = ~level_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      wheel3_q      <= 1'b0;
      win_q         <= '0;
      pulse_q       <= '0;
      sat_hit_q     <= 1'b0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      db_cnt_q      <= '0;
      level_q       <= '0;
      level_dly_q   <= '0;
      rise_q        <= '0;
`ifdef GIC_SPEED_AVG_EN
      prev_q        <= '0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      wheel3_q      <= wheel3_d;
      win_q         <= win_d;
      pulse_q       <= pulse_d;
      sat_hit_q     <= sat_hit_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
      overflow_q    <= overflow_d;
      db_cnt_q      <= db_cnt_d;
      level_q       <= level_d;
      level_dly_q   <= level_dly_d;
      rise_q        <= rise_d;
`ifdef GIC_SPEED_AVG_EN
      prev_q        <= prev_d;
`endif
    end
  end

  assign bus.speed       = speed_q;
  assign bus.speed_valid = speed_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.btn_level   = level_q;
  assign bus.btn_rise    = rise_q;

endmodule

// File: tb/tb_gear_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_gear_input_conditioner
//
// Two conditioners (SPEED_W=8 and SPEED_W=4) share one stimulus stream.
// The reference model works on enabled clock edges since reset release:
//   - a wheel sample that rises at enabled edge n is counted at edge n+2;
//   - every GATE_CYCLES-th enabled edge closes a window and must strobe;
//   - a button level toggles at edge n when the samples taken at edges
//     n-1-D .. n-2 all differ from the level; the rise pulse follows at
//     the next enabled edge.
// Expected speed reports go into per-DUT queues; expected button outputs
// into a per-edge queue. A monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_gear_input_conditioner;

  localparam int G  = 100;
  localparam int D  = 4;
  localparam int EW = 41;  // {stamp[31:0], overflow, speed[7:0]}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gear_input_conditioner_if #(.SPEED_W(8)) bus8 ();
  gear_input_conditioner_if #(.SPEED_W(4)) bus4 ();

  gear_input_conditioner #(.GATE_CYCLES(G), .DEBOUNCE_CYCLES(D), .SPEED_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  gear_input_conditioner #(.GATE_CYCLES(G), .DEBOUNCE_CYCLES(D), .SPEED_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // ---------------- clock / edge counter ----------------
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp8_q[$];
  logic [EW-1:0] exp4_q[$];
  logic [37:0]   btn_q[$];   // {stamp[31:0], level[2:0], rise[2:0]}
  int checks = 0;
  int errors = 0;

  // ---------------- reference model state ----------------
  int         e;
  logic       prev_w;
  int         det_q[$];
  int         acc;
  int         prev8, prev4;
  logic [2:0] hist[$];
  logic [2:0] lvl;
  logic [2:0] rose;

  // current drive values
  logic       w_cur;
  logic [2:0] btn_cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // One clock: drive inputs, advance the model for the coming edge, wait.
  task automatic step(input logic r, input logic en, input logic w, input logic [2:0] b);
    int          edge_n;
    logic [31:0] stamp;
    int          s8, s4, o8, o4;
    logic [2:0]  rise_now;
    logic [2:0]  new_rose;
    logic        all_diff;
    logic        s;
    rst            = r;
    bus8.ena       = en;
    bus4.ena       = en;
    bus8.wheel_raw = w;
    bus4.wheel_raw = w;
    bus8.btn_raw   = b;
    bus4.btn_raw   = b;
    edge_n = int'(cyc) + 1;
    stamp  = edge_n;
    if (r) begin
      e = 0; prev_w = 1'b0; det_q.delete(); acc = 0; prev8 = 0; prev4 = 0;
      hist.delete(); lvl = '0; rose = '0;
      btn_q.push_back({stamp, 3'b000, 3'b000});
    end else if (en) begin
      e++;
      if (w && !prev_w) det_q.push_back(e + 2);
      prev_w = w;
      while (det_q.size() > 0 && det_q[0] == e) begin
        void'(det_q.pop_front());
        acc++;
      end
      if (e % G == 0) begin
        s8 = sat(acc, 8);
        s4 = sat(acc, 4);
`ifdef GIC_SPEED_AVG_EN
        o8 = (s8 + prev8) / 2; prev8 = s8;
        o4 = (s4 + prev4) / 2; prev4 = s4;
`else
        o8 = s8;
        o4 = s4;
`endif
        exp8_q.push_back({stamp, (acc > 255), o8[7:0]});
        exp4_q.push_back({stamp, (acc > 15), o4[7:0]});
        acc = 0;
      end
      rise_now = rose;
      hist.push_back(b);
      new_rose = '0;
      for (int k = 0; k < 3; k++) begin
        all_diff = 1'b1;
        for (int i = e - 1 - D; i <= e - 2; i++) begin
          s = (i >= 1) ? hist[i-1][k] : 1'b0;
          if (s == lvl[k]) all_diff = 1'b0;
        end
        if (all_diff) begin
          lvl[k]      = ~lvl[k];
          new_rose[k] = lvl[k];
        end
      end
      rose = new_rose;
      btn_q.push_back({stamp, lvl, rise_now});
    end else begin
      btn_q.push_back({stamp, lvl, 3'b000});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b1, w_cur, btn_cur);
  endtask

  // Idle until the next enabled edge opens a new window.
  task automatic align();
    w_cur = 1'b0;
    for (int i = 0; i < G && (e % G) != 0; i++) step(1'b0, 1'b1, 1'b0, btn_cur);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      w_cur = 1'b1; run(hi);
      w_cur = 1'b0; run(lo);
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] x8, x4;
  logic [37:0]   bx;
  always @(negedge clk) begin
    if (exp8_q.size() > 0 && exp8_q[0][40:9] < cyc) begin
      x8 = exp8_q.pop_front();
      checks++; errors++;
      $display("FAIL spd8_missing: no strobe at cycle %0d (required speed=%0d)", x8[40:9], x8[7:0]);
    end
    if (exp4_q.size() > 0 && exp4_q[0][40:9] < cyc) begin
      x4 = exp4_q.pop_front();
      checks++; errors++;
      $display("FAIL spd4_missing: no strobe at cycle %0d (required speed=%0d)", x4[40:9], x4[7:0]);
    end
    if (bus8.speed_valid === 1'b1) begin
      if (exp8_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spd8_unexpected: strobe at cycle %0d, none required", cyc);
      end else begin
        x8 = exp8_q.pop_front();
        chk("spd8_time", 64'(cyc), 64'(x8[40:9]));
        chk("spd8_speed", 64'(bus8.speed), 64'(x8[7:0]));
        chk("spd8_ovf", 64'(bus8.overflow), 64'(x8[8]));
      end
    end
    if (bus4.speed_valid === 1'b1) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spd4_unexpected: strobe at cycle %0d, none required", cyc);
      end else begin
        x4 = exp4_q.pop_front();
        chk("spd4_time", 64'(cyc), 64'(x4[40:9]));
        chk("spd4_speed", 64'(bus4.speed), 64'(x4[3:0]));
        chk("spd4_ovf", 64'(bus4.overflow), 64'(x4[8]));
      end
    end
    while (btn_q.size() > 0 && btn_q[0][37:6] <= cyc) begin
      bx = btn_q.pop_front();
      chk("btn_level8", 64'(bus8.btn_level), 64'(bx[5:3]));
      chk("btn_rise8", 64'(bus8.btn_rise), 64'(bx[2:0]));
      chk("btn_level4", 64'(bus4.btn_level), 64'(bx[5:3]));
      chk("btn_rise4", 64'(bus4.btn_rise), 64'(bx[2:0]));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int dens;
  initial begin
    w_cur = 1'b0; btn_cur = '0;
    e = 0; prev_w = 1'b0; acc = 0; prev8 = 0; prev4 = 0; lvl = '0; rose = '0;

    // Reset: three clocks idle, then all outputs must be 0.
    repeat (3) step(1'b1, 1'b1, 1'b0, 3'b000);
    chk("rst_speed8", 64'(bus8.speed), 64'd0);
    chk("rst_valid8", 64'(bus8.speed_valid), 64'd0);
    chk("rst_ovf8", 64'(bus8.overflow), 64'd0);
    chk("rst_speed4", 64'(bus4.speed), 64'd0);
    chk("rst_valid4", 64'(bus4.speed_valid), 64'd0);
    chk("rst_ovf4", 64'(bus4.overflow), 64'd0);

    // First window idle.
    run(G);

    // Count: 10 pulses of period 6, then an idle window.
    align(); pulses(10, 3, 3); align();
    run(G);

    // Saturation: 30 pulses of period 3, then 3 pulses.
    align(); pulses(30, 1, 2); align();
    pulses(3, 1, 2); align();

    // Debounce: throttle 1,0,1 then hold; 3-cycle brake glitch; releases.
    btn_cur[0] = 1'b1; run(1);
    btn_cur[0] = 1'b0; run(1);
    btn_cur[0] = 1'b1; run(12);
    btn_cur[1] = 1'b1; run(3);
    btn_cur[1] = 1'b0; run(10);
    btn_cur[2] = 1'b1; run(10);
    btn_cur[0] = 1'b0; btn_cur[2] = 1'b0; run(10);

    // Reset mid-window: 7 pulses, reset near window count 50, 4 pulses.
    align(); pulses(7, 3, 3); run(8);
    step(1'b1, 1'b1, 1'b0, btn_cur);
    pulses(4, 3, 3); align();

    // Enable low while the wheel and a button move.
    pulses(3, 2, 2);
    btn_cur[1] = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, i[0], btn_cur);
    pulses(2, 2, 2); run(5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, btn_cur);
    run(5); btn_cur[1] = 1'b0; align();

    // Randomized traffic.
    dens = 3;
    for (int c = 0; c < 2500; c++) begin
      if (c % 100 == 0) dens = $urandom_range(0, 6);
      if ($urandom_range(0, dens) == 0) w_cur = ~w_cur;
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 11) == 0) btn_cur[k] = ~btn_cur[k];
      if ($urandom_range(0, 1199) == 0)
        step(1'b1, 1'b1, w_cur, btn_cur);
      else if ($urandom_range(0, 39) == 0)
        step(1'b0, 1'b0, w_cur, btn_cur);
      else
        step(1'b0, 1'b1, w_cur, btn_cur);
    end

    // Drain outstanding windows.
    w_cur = 1'b0; btn_cur = '0;
    run(2 * G + 10);
    chk("drain8", 64'(exp8_q.size()), 64'd0);
    chk("drain4", 64'(exp4_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gear_input_conditioner.md
# gear_input_conditioner

Front-end stage directly upstream of the automatic-gearbox FSM. Synchronizes and conditions raw pad inputs: measures wheel-pulse rate over a fixed gate window and debounces the driver buttons. Delivers a clean speed code, per-window strobe and debounced button levels and edges. The shift FSM consumes these outputs unchanged.

## Interface
- GATE_CYCLES, 25000: clocks per speed-measurement window (1 s at 25 kHz); ≥2.
- DEBOUNCE_CYCLES, 250: consecutive stable clocks required to accept a button change; ≥1.
- SPEED_W, 8: width of speed code.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design enable; low freezes the block.
- wheel_raw  in  1  asynchronous wheel-sensor pulse.
- btn_raw  in  3  asynchronous buttons: [0] throttle, [1] brake, [2] drive/park.
- speed  out  SPEED_W  rising wheel edges counted in last completed window, saturated.
- speed_valid  out  1  one-cycle strobe when speed updates.
- overflow  out  1  last completed window saturated; updates with speed.
- btn_level  out  3  debounced button levels.
- btn_rise  out  3  one-cycle pulse on debounced 0→1 of each button.

## Operation
- All four raw inputs pass through a 2-FF synchronizer. A third FF on the wheel path provides edge detection: an edge is s2=1 and s3=0.
- Window counter runs 0..GATE_CYCLES-1 and wraps. Pulse counter increments on each detected edge and saturates at 2^SPEED_W-1.
- Terminal cycle (window count = GATE_CYCLES-1):
  - speed ← pulse count (including an edge detected that cycle).
  - overflow ← 1 if a further edge arrived while the count was saturated, else 0.
  - speed_valid ← 1.
  - Pulse counter clears to 0. An edge detected on the cycle after terminal counts toward the new window.
- Debounce, per button (one counter each):
  - If synchronized input ≠ btn_level, counter increments. On the clock where it would reach DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
  - Any cycle with input = btn_level clears the counter.
  - btn_rise pulses high for exactly the cycle after btn_level goes 0→1. A falling level produces no pulse.
- ena low:
  - Synchronizers, counters, speed, overflow and btn_level hold.
  - speed_valid and btn_rise are forced 0.
  - Edges are not recorded while ena is low.
- rst dominates ena.

## Timing
- Reset values: speed 0, speed_valid 0, overflow 0, btn_level 0, btn_rise 0. All counters and synchronizer FFs are also 0.
- Wheel: a raw rising edge stable before clock edge 0 is detected (counted) at edge 2.
- First speed_valid after rst deasserts occurs at the GATE_CYCLES-th clock edge. It then repeats every GATE_CYCLES clocks while ena=1.
- Button: raw changes before edge 0 and stays stable. btn_level changes at edge DEBOUNCE_CYCLES+1 and is visible after it. btn_rise asserts after edge DEBOUNCE_CYCLES+2 for one cycle.
- Rise of btn_level and btn_rise never coincide. The shift FSM samples btn_rise as a pulse.
- Reset mid-window discards the partial count and restarts the window at 0.
- Minimum resolvable wheel period is 2 clocks (high ≥1, low ≥1 synchronized cycle).

## Configuration
- GIC_SPEED_AVG_EN defined:
  - speed = (current window count + previous window count) >> 1, using a SPEED_W+1-bit sum and saturated counts.
  - Previous count resets to 0.
  - overflow reflects the current window only.
- Undefined: speed is the raw current-window count, and no previous-count register exists.

## Test plan
Parameters: GATE_CYCLES=100, DEBOUNCE_CYCLES=4, SPEED_W=8 unless noted.
- **Reset:** hold rst 3 clocks with wheel_raw/btn_raw idle → all outputs 0. First speed_valid comes 100 edges after release with speed=0, overflow=0.
- **Count:** 10 wheel pulses of period 6 clocks inside one window → speed=10 at next speed_valid; following idle window → speed=0.
- **Saturation:** SPEED_W=4, 30 pulses of period 3 in one window → speed=15, overflow=1; next window with 3 pulses → speed=3, overflow=0.
- **Debounce:**
  - throttle raw toggles 1,0,1 on consecutive clocks then holds 1 → btn_level[0] rises 5 edges after the last toggle; btn_rise[0] high exactly one cycle.
  - 3-cycle brake glitch → no change on btn_level[1] or btn_rise[1].
- **Reset mid-window:** 7 pulses, pulse rst at window count 50, then 4 pulses → first speed_valid 100 clocks after release reports speed=4.
- **Averaging** (GIC_SPEED_AVG_EN): windows of 10 then 20 pulses → speed=5 then 15.
